// File: rtl/mem_arbiter2.sv
// Two-master arbiter for the picorv32 native memory bus, with a bus watchdog
// that completes unanswered transactions and records the failing address.
module mem_arbiter2 #(
    parameter int          PRIORITY_MODE  = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hBADC_0DE0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    input  logic        err_clr,
    output logic        timeout_err,
    output logic [31:0] timeout_addr,
    output logic [1:0]  grant
);

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        last_reg, last_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        err_reg, err_next;
    logic [31:0] taddr_reg, taddr_next;

    // Master ports gathered into arrays so per-master logic is written once.
    logic [1:0]  m_valid;
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic [1:0]  m_ready;
    logic [31:0] m_rdata [2];

    assign m_valid    = {m1_valid, m0_valid};
    assign m_addr[0]  = m0_addr;
    assign m_addr[1]  = m1_addr;
    assign m_wdata[0] = m0_wdata;
    assign m_wdata[1] = m1_wdata;
    assign m_wstrb[0] = m0_wstrb;
    assign m_wstrb[1] = m1_wstrb;

    logic [1:0] own;
    logic       busy;
    logic       fire;
    logic       sel;

    assign own  = (state_reg == ST_BUSY0) ? 2'b01 :
                  (state_reg == ST_BUSY1) ? 2'b10 : 2'b00;
    assign busy = |own;
    assign sel  = own[1];
    // A slave answering in the limit cycle takes precedence over the watchdog.
    assign fire = busy && (cnt_reg == TIMEOUT_LIMIT) && !mem_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign m_ready[gi] = own[gi] & (mem_ready | fire);
            assign m_rdata[gi] = (own[gi] && fire) ? TIMEOUT_RDATA : mem_rdata;
        end
    endgenerate

    assign m0_ready = m_ready[0];
    assign m1_ready = m_ready[1];
    assign m0_rdata = m_rdata[0];
    assign m1_rdata = m_rdata[1];

    assign grant        = own;
    assign timeout_err  = err_reg;
    assign timeout_addr = taddr_reg;

    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        if (busy) begin
            mem_valid = !fire;
            mem_addr  = m_addr[sel];
            mem_wdata = m_wdata[sel];
            mem_wstrb = m_wstrb[sel];
        end
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg & ~err_clr;
        taddr_next = taddr_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = 16'd0;
                if (m_valid == 2'b11) begin
                    // last_reg = 1 means master 1 was served last.
                    if (PRIORITY_MODE == 1 || last_reg)
                        state_next = ST_BUSY0;
                    else
                        state_next = ST_BUSY1;
                end else if (m_valid[0]) begin
                    state_next = ST_BUSY0;
                end else if (m_valid[1]) begin
                    state_next = ST_BUSY1;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (mem_ready || fire) begin
                    state_next = ST_IDLE;
                    last_next  = sel;
                    if (fire) begin
                        err_next   = 1'b1;
                        taddr_next = m_addr[sel];
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            last_reg  <= 1'b1;
            cnt_reg   <= 16'd0;
            err_reg   <= 1'b0;
            taddr_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            taddr_reg <= taddr_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2: a round-robin and a fixed-priority instance
// share master stimulus; each has its own slave-ready source.
module tb_mem_arbiter2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0] mem_rdata = '0;
    logic        err_clr = 1'b0;
    logic        auto_slave = 1'b0;
    logic        ready_drv = 1'b0;

    logic        rr_m0_ready, rr_m1_ready, rr_mem_valid, rr_mem_ready, rr_err;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_mem_addr, rr_mem_wdata, rr_taddr;
    logic [3:0]  rr_mem_wstrb;
    logic [1:0]  rr_grant;

    logic        fp_m0_ready, fp_m1_ready, fp_mem_valid, fp_mem_ready, fp_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata, fp_taddr;
    logic [3:0]  fp_mem_wstrb;
    logic [1:0]  fp_grant;

    int n_cmp = 0;
    int n_err = 0;

    // Zero-wait slave answers whenever a grant is held (registered, so no loop).
    assign rr_mem_ready = auto_slave ? (rr_grant != 2'b00) : ready_drv;
    assign fp_mem_ready = auto_slave ? (fp_grant != 2'b00) : ready_drv;

    always #5 clk = ~clk;

    mem_arbiter2 #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata),
        .mem_valid(rr_mem_valid), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_wstrb(rr_mem_wstrb), .mem_ready(rr_mem_ready), .mem_rdata(mem_rdata),
        .err_clr(err_clr), .timeout_err(rr_err), .timeout_addr(rr_taddr), .grant(rr_grant)
    );

    mem_arbiter2 #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(4)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
        .mem_valid(fp_mem_valid), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_wstrb(fp_mem_wstrb), .mem_ready(fp_mem_ready), .mem_rdata(mem_rdata),
        .err_clr(err_clr), .timeout_err(fp_err), .timeout_addr(fp_taddr), .grant(fp_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_grant",   {30'd0, rr_grant}, 32'd0);
        chk("rst_valid",   {31'd0, rr_mem_valid}, 32'd0);
        chk("rst_ready",   {30'd0, rr_m1_ready, rr_m0_ready}, 32'd0);
        chk("rst_err",     {31'd0, rr_err}, 32'd0);
        chk("rst_taddr",   rr_taddr, 32'd0);
        chk("rst_fp_grant", {30'd0, fp_grant}, 32'd0);
        $display("txn reset: idle state checked");

        // Single master 0 read, slave answers in first BUSY cycle
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
        tick();
        chk("rd_grant", {30'd0, rr_grant}, 32'd1);
        chk("rd_addr",  rr_mem_addr, 32'h0000_0010);
        ready_drv = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("rd_valid", {31'd0, rr_mem_valid}, 32'd1);
        chk("rd_ready", {30'd0, rr_m1_ready, rr_m0_ready}, 32'd1);
        chk("rd_rdata", rr_m0_rdata, 32'h1234_5678);
        tick();
        m0_valid = 1'b0; ready_drv = 1'b0;
        #1;
        chk("rd_idle_valid", {31'd0, rr_mem_valid}, 32'd0);
        chk("rd_idle_grant", {30'd0, rr_grant}, 32'd0);
        chk("rd_idle_ready", {31'd0, rr_m0_ready}, 32'd0);
        $display("txn m0 read 0x00000010: rdata %h", 32'h1234_5678);

        // Both masters continuously requesting, zero-wait slave
        do_reset();
        auto_slave = 1'b1; mem_rdata = 32'h0000_00A5;
        m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tie_rr_grant", {30'd0, rr_grant}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("tie_rr_ready", {30'd0, rr_m1_ready, rr_m0_ready},
                (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("tie_fp_grant", {30'd0, fp_grant}, 32'd1);
            chk("tie_fp_m1rdy", {31'd0, fp_m1_ready}, 32'd0);
            tick();
            if (i == 3) begin
                m0_valid = 1'b0; m1_valid = 1'b0;
            end
            chk("tie_idle_valid", {31'd0, rr_mem_valid}, 32'd0);
            chk("tie_idle_grant", {30'd0, rr_grant}, 32'd0);
            $display("txn tie %0d: rr grant %b fp grant 01", i, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        auto_slave = 1'b0;
        tick();

        // Master 1 write, no slave: watchdog fires at N+5
        m1_valid = 1'b1; m1_addr = 32'h9000_0000; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
        tick();
        chk("to_grant", {30'd0, rr_grant}, 32'd2);
        chk("to_wstrb", {28'd0, rr_mem_wstrb}, 32'hF);
        chk("to_wdata", rr_mem_wdata, 32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("to_wait_ready", {31'd0, rr_m1_ready}, 32'd0);
            chk("to_wait_valid", {31'd0, rr_mem_valid}, 32'd1);
        end
        tick();
        chk("to_fire_ready", {31'd0, rr_m1_ready}, 32'd1);
        chk("to_fire_rdata", rr_m1_rdata, 32'hBADC_0DE0);
        chk("to_fire_valid", {31'd0, rr_mem_valid}, 32'd0);
        chk("to_fire_err",   {31'd0, rr_err}, 32'd0);
        m1_valid = 1'b0;
        tick();
        chk("to_err",   {31'd0, rr_err}, 32'd1);
        chk("to_taddr", rr_taddr, 32'h9000_0000);
        chk("to_grant_idle", {30'd0, rr_grant}, 32'd0);
        $display("txn m1 write 0x90000000: watchdog completion");

        // err_clr alone clears the flag
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err", {31'd0, rr_err}, 32'd0);
        $display("txn err_clr: flag cleared");

        // mem_ready exactly on the limit cycle
        m0_valid = 1'b1; m0_addr = 32'h0000_0020;
        for (int c = 0; c < 5; c++) tick();
        ready_drv = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("lim_ready", {31'd0, rr_m0_ready}, 32'd1);
        chk("lim_rdata", rr_m0_rdata, 32'hCAFE_F00D);
        chk("lim_valid", {31'd0, rr_mem_valid}, 32'd1);
        tick();
        m0_valid = 1'b0; ready_drv = 1'b0;
        chk("lim_err",  {31'd0, rr_err}, 32'd0);
        chk("lim_idle", {30'd0, rr_grant}, 32'd0);
        $display("txn m0 read 0x00000020: ready on limit cycle");

        // Timeout to set the flag, then a second timeout coinciding with err_clr
        m1_valid = 1'b1; m1_addr = 32'h9000_0004;
        for (int c = 0; c < 5; c++) tick();
        chk("to2_fire", {31'd0, rr_m1_ready}, 32'd1);
        m1_valid = 1'b0;
        tick();
        chk("to2_err", {31'd0, rr_err}, 32'd1);
        m0_valid = 1'b1; m0_addr = 32'h0000_0044;
        for (int c = 0; c < 5; c++) tick();
        chk("to3_fire", {31'd0, rr_m0_ready}, 32'd1);
        chk("to3_rdata", rr_m0_rdata, 32'hBADC_0DE0);
        err_clr = 1'b1; m0_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        chk("to3_err_set_wins", {31'd0, rr_err}, 32'd1);
        chk("to3_taddr", rr_taddr, 32'h0000_0044);
        $display("txn m0 timeout 0x00000044 with err_clr: flag held");

        // Reset mid-BUSY1
        m1_valid = 1'b1; m1_addr = 32'h0000_0300;
        tick();
        chk("mid_grant", {30'd0, rr_grant}, 32'd2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", {30'd0, rr_grant}, 32'd0);
        chk("mid_rst_valid", {31'd0, rr_mem_valid}, 32'd0);
        chk("mid_rst_ready", {30'd0, rr_m1_ready, rr_m0_ready}, 32'd0);
        chk("mid_rst_err",   {31'd0, rr_err}, 32'd0);
        m1_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        $display("txn reset mid-BUSY1: aborted");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
